// File: rtl/xdma.sv
// Single-channel memory-to-memory DMA engine copying LEN words from SRC to DST.
// Each word takes a read, a capture and a write cycle on the shared memory port.
module xdma #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_sel,
    input  logic              ctrl_we,
    input  logic [1:0]        ctrl_addr,
    input  logic [DATA_W-1:0] ctrl_data_in,
    output logic [DATA_W-1:0] ctrl_data_out,
    output logic              dma_sel,
    output logic              dma_we,
    output logic [MEM_AW-1:0] dma_addr,
    output logic [DATA_W-1:0] dma_data_in,
    input  logic [DATA_W-1:0] dma_data_out,
    input  logic              mem_busy,
    output logic              irq
);

    localparam int LW = MEM_AW + 1;
    localparam logic [MEM_AW-1:0] ONE_A = 1;
    localparam logic [LW-1:0]     ONE_L = 1;

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    state_t              state_q;
    logic [LW-1:0]       src_q, dst_q, len_q, rem_q;
    logic [MEM_AW-1:0]   sptr_q, dptr_q, addr_q;
    logic [DATA_W-1:0]   buf_q, rdata_q;
    logic                done_q, irq_q, sel_q, we_q;

    logic                wr_en, rd_en, is_ctrl, start, abort, busy;
    logic [LW-1:0]       rem_d;
    logic [MEM_AW-1:0]   sptr_d, dptr_d;
    logic [DATA_W-1:0]   status, rd_mux;
    logic                unused_data;

    assign unused_data = ^ctrl_data_in[DATA_W-1:LW];

    always_comb begin
        wr_en   = ctrl_sel & ctrl_we;
        rd_en   = ctrl_sel & ~ctrl_we;
        is_ctrl = (ctrl_addr == 2'd3);
        abort   = wr_en & is_ctrl & ctrl_data_in[1];
        start   = wr_en & is_ctrl & ctrl_data_in[0] & ~ctrl_data_in[1];
        busy    = (state_q != IDLE);
        rem_d   = rem_q - ONE_L;
        sptr_d  = sptr_q + ONE_A;
        dptr_d  = dptr_q + ONE_A;
    end

    always_comb begin
        status             = '0;
        status[DATA_W-1]   = busy;
        status[DATA_W-2]   = done_q;
        status[LW-1:0]     = rem_q;
        rd_mux             = '0;
        case (ctrl_addr)
            2'd0:    rd_mux[LW-1:0] = src_q;
            2'd1:    rd_mux[LW-1:0] = dst_q;
            2'd2:    rd_mux[LW-1:0] = len_q;
            default: rd_mux = status;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            sptr_q  <= '0;
            dptr_q  <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (rd_en) rdata_q <= rd_mux;
            // Configuration is frozen while a copy is in flight
            if (wr_en && !busy) begin
                case (ctrl_addr)
                    2'd0:    src_q <= ctrl_data_in[LW-1:0];
                    2'd1:    dst_q <= ctrl_data_in[LW-1:0];
                    2'd2:    len_q <= ctrl_data_in[LW-1:0];
                    default: ;
                endcase
            end
            if (abort) begin
                state_q <= IDLE;
                sel_q   <= 1'b0;
                we_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            done_q <= 1'b0;
                            sptr_q <= src_q[MEM_AW-1:0];
                            dptr_q <= dst_q[MEM_AW-1:0];
                            rem_q  <= len_q;
                            if (len_q == '0) begin
                                done_q <= 1'b1;
                                irq_q  <= 1'b1;
                            end else begin
                                state_q <= RD;
                                sel_q   <= 1'b1;
                                we_q    <= 1'b0;
                                addr_q  <= src_q[MEM_AW-1:0];
                            end
                        end
                    end
                    RD: begin
                        if (!mem_busy) begin
                            state_q <= CAP;
                            sel_q   <= 1'b0;
                        end
                    end
                    CAP: begin
                        buf_q   <= dma_data_out;
                        state_q <= WR;
                        sel_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= dptr_q;
                    end
                    WR: begin
                        if (!mem_busy) begin
                            sptr_q <= sptr_d;
                            dptr_q <= dptr_d;
                            rem_q  <= rem_d;
                            we_q   <= 1'b0;
                            if (rem_d != '0) begin
                                state_q <= RD;
                                sel_q   <= 1'b1;
                                addr_q  <= sptr_d;
                            end else begin
                                state_q <= IDLE;
                                sel_q   <= 1'b0;
                                done_q  <= 1'b1;
                                irq_q   <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ctrl_data_out = rdata_q;
    assign dma_sel       = sel_q;
    assign dma_we        = we_q;
    assign dma_addr      = addr_q;
    assign dma_data_in   = buf_q;
    assign irq           = irq_q;

endmodule
